protocol_tx_dispatcher: RTL and testbench

PROTOCOL_TX_DISPATCHER -- requirements
Module: protocol_tx_dispatcher

---
 rtl/protocol_tx_dispatcher.sv | 225 ++++++++++++++++++++++
 tb/tb_protocol_tx_dispatcher.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/protocol_tx_dispatcher.sv
// Host byte queue that launches one transfer at a time on the SPI, I2C or UART engine.
// Optional WAIT_DONE watchdog is compiled in when DISPATCH_TIMEOUT_EN is defined.

// Generic circular FIFO with an occupancy count and a combinational head.
// Latency: a pushed entry becomes visible at the head on the edge after the write.
// Backpressure: push_rdy drops when full; a pop on an empty FIFO is ignored.
module dispatch_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_vld,
    input  logic [W-1:0]           push_dat,
    output logic                   push_rdy,
    input  logic                   pop_vld,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_rdy = (count < CNT_W'(DEPTH));
    assign push_ok  = push_vld && push_rdy;
    assign pop_ok   = pop_vld && (count != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Pops queued bytes and issues each to the one-hot selected engine, one in flight.
// Latency: byte accepted on edge N gives a start pulse in the cycle after edge N+2.
// Backpressure: in_ready low when the FIFO is full; engine completion gates the next issue.
module protocol_tx_dispatcher #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [2:0]             select,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_W-1:0]      tx_data,
    output logic                   SPI_start,
    output logic                   I2C_start,
    output logic                   Ux_start,
    input  logic                   SPI_busy,
    input  logic                   I2C_busy,
    input  logic                   Ux_busy,
    input  logic                   SPI_valid,
    input  logic                   I2C_valid,
    input  logic                   Ux_valid,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   sel_error,
    output logic                   timeout
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_t;

    state_t            state;
    logic [2:0]        target;
    logic [DATA_W-1:0] head_dat;
    logic              sel_onehot;
    logic              fifo_nonempty;
    logic              pop;
    logic              target_done;
    logic              unused_busy;

    dispatch_fifo #(
        .W     (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_vld (in_valid),
        .push_dat (in_data),
        .push_rdy (in_ready),
        .pop_vld  (pop),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    assign sel_onehot    = (select == 3'b001) || (select == 3'b010) || (select == 3'b100);
    assign fifo_nonempty = (fifo_count != '0);
    assign pop           = (state == IDLE) && fifo_nonempty && sel_onehot;
    // Only the latched engine can end a transfer; the others are never looked at.
    assign target_done   = |(target & {Ux_valid, I2C_valid, SPI_valid});
    // Busy lines are informational; completion is signalled by *_valid alone.
    assign unused_busy   = SPI_busy | I2C_busy | Ux_busy;

`ifdef DISPATCH_TIMEOUT_EN
    logic [TMR_W-1:0] timer;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            target    <= 3'b000;
            tx_data   <= '0;
            SPI_start <= 1'b0;
            I2C_start <= 1'b0;
            Ux_start  <= 1'b0;
            sel_error <= 1'b0;
            timeout   <= 1'b0;
            timer     <= '0;
        end else begin
            SPI_start <= 1'b0;
            I2C_start <= 1'b0;
            Ux_start  <= 1'b0;
            sel_error <= 1'b0;
            timeout   <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        target  <= select;
                        tx_data <= head_dat;
                        state   <= ISSUE;
                    end else if (fifo_nonempty) begin
                        sel_error <= 1'b1;
                    end
                end
                ISSUE: begin
                    {Ux_start, I2C_start, SPI_start} <= target;
                    timer <= '0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (target_done) begin
                        timer <= '0;
                        state <= IDLE;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        // The abandoned byte is not retried.
                        timeout <= 1'b1;
                        timer   <= '0;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic [TMR_W-1:0] unused_timeout_cfg;

    assign unused_timeout_cfg = TMR_W'(TIMEOUT);
    assign timeout            = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            target    <= 3'b000;
            tx_data   <= '0;
            SPI_start <= 1'b0;
            I2C_start <= 1'b0;
            Ux_start  <= 1'b0;
            sel_error <= 1'b0;
        end else begin
            SPI_start <= 1'b0;
            I2C_start <= 1'b0;
            Ux_start  <= 1'b0;
            sel_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        target  <= select;
                        tx_data <= head_dat;
                        state   <= ISSUE;
                    end else if (fifo_nonempty) begin
                        sel_error <= 1'b1;
                    end
                end
                ISSUE: begin
                    {Ux_start, I2C_start, SPI_start} <= target;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (target_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_protocol_tx_dispatcher.sv
// Directed bench for protocol_tx_dispatcher (DEPTH 4, TIMEOUT 10).
module tb_protocol_tx_dispatcher;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 10;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [2:0]        select = 3'b000;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] tx_data;
    logic              SPI_start, I2C_start, Ux_start;
    logic              SPI_busy = 1'b0, I2C_busy = 1'b0, Ux_busy = 1'b0;
    logic              SPI_valid = 1'b0, I2C_valid = 1'b0, Ux_valid = 1'b0;
    logic [2:0]        fifo_count;
    logic              sel_error;
    logic              timeout;

    int checks = 0;
    int errors = 0;

    logic [7:0] log_dat [0:63];
    logic [2:0] log_eng [0:63];
    int         log_n = 0;
    int         to_n = 0;

    always #5 clk = ~clk;

    protocol_tx_dispatcher #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .select     (select),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx_data    (tx_data),
        .SPI_start  (SPI_start),
        .I2C_start  (I2C_start),
        .Ux_start   (Ux_start),
        .SPI_busy   (SPI_busy),
        .I2C_busy   (I2C_busy),
        .Ux_busy    (Ux_busy),
        .SPI_valid  (SPI_valid),
        .I2C_valid  (I2C_valid),
        .Ux_valid   (Ux_valid),
        .fifo_count (fifo_count),
        .sel_error  (sel_error),
        .timeout    (timeout)
    );

    // Record every start pulse with the byte presented alongside it.
    always @(negedge clk) begin
        if ({Ux_start, I2C_start, SPI_start} != 3'b000) begin
            if (log_n < 64) begin
                log_dat[log_n] = tx_data;
                log_eng[log_n] = {Ux_start, I2C_start, SPI_start};
            end
            log_n++;
        end
        if (timeout) to_n++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        in_data = d; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        checks++; if ({Ux_start, I2C_start, SPI_start} !== 3'b000) begin errors++; $display("FAIL reset_starts: got %b want 000", {Ux_start, I2C_start, SPI_start}); end
        checks++; if (sel_error !== 1'b0) begin errors++; $display("FAIL reset_sel_error: got %b want 0", sel_error); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick;
    endtask

    task automatic test_spi;
        int b;
        b = log_n;
        select = 3'b001;
        push(8'hA5);
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL spi_count_after_push: got %0d want 1", fifo_count); end
        tick;
        checks++; if ({Ux_start, I2C_start, SPI_start} !== 3'b000) begin errors++; $display("FAIL spi_early_start: got %b want 000", {Ux_start, I2C_start, SPI_start}); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL spi_pop: got %0d want 0", fifo_count); end
        tick;
        checks++; if ({Ux_start, I2C_start, SPI_start} !== 3'b001) begin errors++; $display("FAIL spi_start: got %b want 001", {Ux_start, I2C_start, SPI_start}); end
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL spi_tx_data: got %h want a5", tx_data); end
        tick;
        checks++; if ({Ux_start, I2C_start, SPI_start} !== 3'b000) begin errors++; $display("FAIL spi_start_width: got %b want 000", {Ux_start, I2C_start, SPI_start}); end
        SPI_valid = 1'b1; tick; SPI_valid = 1'b0; tick;
        checks++; if (log_n - b !== 1) begin errors++; $display("FAIL spi_pulse_count: got %0d want 1", log_n - b); end
    endtask

    task automatic test_fifo_full;
        int b;
        b = log_n;
        select = 3'b010;
        // First byte launches and stalls; the next four fill the queue.
        for (int i = 1; i <= 5; i++) begin
            in_data = 8'(i); in_valid = 1'b1;
            tick;
        end
        in_data = 8'h06;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", fifo_count); end
        tick;
        in_valid = 1'b0;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_reject: got %0d want 4", fifo_count); end
        for (int i = 0; i < 5; i++) begin
            I2C_valid = 1'b1; tick; I2C_valid = 1'b0;
            tick; tick; tick;
        end
        checks++; if (log_n - b !== 5) begin errors++; $display("FAIL full_issue_count: got %0d want 5", log_n - b); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (log_dat[b+k] !== 8'(k + 1)) begin errors++; $display("FAIL full_order[%0d]: got %h want %h", k, log_dat[b+k], 8'(k + 1)); end
            checks++; if (log_eng[b+k] !== 3'b010) begin errors++; $display("FAIL full_engine[%0d]: got %b want 010", k, log_eng[b+k]); end
        end
        checks++; if (fifo_count !== 3'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL full_drain: got count %0d rdy %b want 0 1", fifo_count, in_ready); end
    endtask

    task automatic test_sel_error;
        int b;
        b = log_n;
        select = 3'b011;
        push(8'h3C);
        tick; tick;
        checks++; if (sel_error !== 1'b1) begin errors++; $display("FAIL selerr_multi: got %b want 1", sel_error); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL selerr_no_pop: got %0d want 1", fifo_count); end
        checks++; if (log_n - b !== 0) begin errors++; $display("FAIL selerr_no_start: got %0d want 0", log_n - b); end
        select = 3'b000;
        tick; tick;
        checks++; if (sel_error !== 1'b1) begin errors++; $display("FAIL selerr_zero: got %b want 1", sel_error); end
        select = 3'b100;
        tick;
        checks++; if (sel_error !== 1'b0) begin errors++; $display("FAIL selerr_clear: got %b want 0", sel_error); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL selerr_pop: got %0d want 0", fifo_count); end
        tick;
        checks++; if ({Ux_start, I2C_start, SPI_start} !== 3'b100) begin errors++; $display("FAIL selerr_ux_start: got %b want 100", {Ux_start, I2C_start, SPI_start}); end
        checks++; if (tx_data !== 8'h3C) begin errors++; $display("FAIL selerr_tx_data: got %h want 3c", tx_data); end
        Ux_valid = 1'b1; tick; Ux_valid = 1'b0; tick;
    endtask

    task automatic test_select_switch;
        int b;
        b = log_n;
        select = 3'b001;
        push(8'h77);
        tick; tick;
        checks++; if ({Ux_start, I2C_start, SPI_start} !== 3'b001) begin errors++; $display("FAIL switch_spi_start: got %b want 001", {Ux_start, I2C_start, SPI_start}); end
        select = 3'b100;
        push(8'h88);
        Ux_valid = 1'b1; Ux_busy = 1'b1; I2C_valid = 1'b1;
        repeat (5) tick;
        checks++; if (log_n - b !== 1) begin errors++; $display("FAIL switch_other_valid_ignored: got %0d starts want 1", log_n - b); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL switch_held: got %0d want 1", fifo_count); end
        Ux_valid = 1'b0; Ux_busy = 1'b0; I2C_valid = 1'b0;
        SPI_valid = 1'b1; tick; SPI_valid = 1'b0;
        tick; tick;
        checks++; if ({Ux_start, I2C_start, SPI_start} !== 3'b100) begin errors++; $display("FAIL switch_next_ux: got %b want 100", {Ux_start, I2C_start, SPI_start}); end
        checks++; if (tx_data !== 8'h88) begin errors++; $display("FAIL switch_next_data: got %h want 88", tx_data); end
        Ux_valid = 1'b1; tick; Ux_valid = 1'b0; tick;
        checks++; if (log_eng[b] !== 3'b001) begin errors++; $display("FAIL switch_first_engine: got %b want 001", log_eng[b]); end
    endtask

    task automatic test_timeout;
        int b;
        int t;
        b = log_n;
        t = to_n;
        select = 3'b001;
        in_data = 8'h11; in_valid = 1'b1; tick;
        in_data = 8'h22; tick;
        in_valid = 1'b0; tick;
        checks++; if ({Ux_start, I2C_start, SPI_start} !== 3'b001 || tx_data !== 8'h11) begin errors++; $display("FAIL to_first_start: got %b/%h want 001/11", {Ux_start, I2C_start, SPI_start}, tx_data); end
`ifdef DISPATCH_TIMEOUT_EN
        repeat (9) tick;
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_early: got %b want 0", timeout); end
        tick;
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b want 1", timeout); end
        tick;
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b want 0", timeout); end
        tick;
        checks++; if ({Ux_start, I2C_start, SPI_start} !== 3'b001 || tx_data !== 8'h22) begin errors++; $display("FAIL to_next_issue: got %b/%h want 001/22", {Ux_start, I2C_start, SPI_start}, tx_data); end
        SPI_valid = 1'b1; tick; SPI_valid = 1'b0; tick;
        checks++; if (to_n - t !== 1) begin errors++; $display("FAIL to_count: got %0d want 1", to_n - t); end
`else
        repeat (300) tick;
        checks++; if (to_n - t !== 0 || timeout !== 1'b0) begin errors++; $display("FAIL to_disabled: got %0d pulses want 0", to_n - t); end
        checks++; if (log_n - b !== 1 || fifo_count !== 3'd1) begin errors++; $display("FAIL to_wait_forever: got %0d starts count %0d want 1 1", log_n - b, fifo_count); end
        SPI_valid = 1'b1; tick; SPI_valid = 1'b0;
        tick; tick;
        checks++; if ({Ux_start, I2C_start, SPI_start} !== 3'b001 || tx_data !== 8'h22) begin errors++; $display("FAIL to_next_issue: got %b/%h want 001/22", {Ux_start, I2C_start, SPI_start}, tx_data); end
        SPI_valid = 1'b1; tick; SPI_valid = 1'b0; tick;
`endif
    endtask

    task automatic test_reset_mid;
        int b;
        select = 3'b010;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'h31 + 8'(i); in_valid = 1'b1;
            tick;
        end
        in_valid = 1'b0;
        tick; tick;
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL rst_mid_queued: got %0d want 3", fifo_count); end
        reset_n = 1'b0;
        #2;
        checks++; if (fifo_count !== 3'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_flush: got count %0d rdy %b want 0 1", fifo_count, in_ready); end
        @(posedge clk); #1;
        b = log_n;
        reset_n = 1'b1;
        repeat (8) tick;
        checks++; if (log_n - b !== 0) begin errors++; $display("FAIL rst_mid_no_start: got %0d starts want 0", log_n - b); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_mid_empty: got %0d want 0", fifo_count); end
        select = 3'b100;
        push(8'h5A);
        tick; tick;
        checks++; if ({Ux_start, I2C_start, SPI_start} !== 3'b100 || tx_data !== 8'h5A) begin errors++; $display("FAIL rst_mid_recover: got %b/%h want 100/5a", {Ux_start, I2C_start, SPI_start}, tx_data); end
        Ux_valid = 1'b1; tick; Ux_valid = 1'b0; tick;
    endtask

    initial begin
        test_reset;
        test_spi;
        test_fifo_full;
        test_sel_error;
        test_select_switch;
        test_timeout;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
